// File: rtl/cgia_vram_arbiter.sv
// Arbiter sharing the VRAM Wishbone slave between the CGIA fetcher (V) and
// the host CPU (C). V has fixed priority; after MAX_RUN consecutive V acks
// with C waiting, C is granted one transfer before V resumes.
module cgia_vram_arbiter #(
  parameter int MAX_RUN = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        v_cyc_i,
  input  logic [22:0] v_adr_i,
  output logic        v_ack_o,
  output logic [15:0] v_dat_o,
  input  logic        c_cyc_i,
  input  logic        c_stb_i,
  input  logic        c_we_i,
  input  logic [1:0]  c_sel_i,
  input  logic [22:0] c_adr_i,
  input  logic [15:0] c_dat_i,
  output logic        c_ack_o,
  output logic [15:0] c_dat_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [1:0]  m_sel_o,
  output logic [22:0] m_adr_o,
  output logic [15:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [15:0] m_dat_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VID  = 2'd1,
    ST_CPU  = 2'd2
  } state_t;

  // Run value at which the next V ack hands one transfer to a waiting CPU.
  localparam logic [7:0] RUN_LAST  = 8'(MAX_RUN - 1);
  localparam bit         STEAL_ENA = (MAX_RUN != 0);

  state_t     state_q, state_d;
  logic [7:0] run_q, run_d;

  logic v_ack;
  logic c_ack;

  // Grant register and run counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      run_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Bus steering: outputs follow the granted master combinationally.
  always_comb begin
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_sel_o = 2'b00;
    m_adr_o = 23'd0;
    m_dat_o = 16'd0;
    v_ack   = 1'b0;
    c_ack   = 1'b0;
    case (state_q)
      ST_VID: begin
        m_cyc_o = v_cyc_i;
        m_stb_o = v_cyc_i;
        m_sel_o = 2'b11;
        m_adr_o = v_adr_i;
        v_ack   = m_ack_i & v_cyc_i;
      end
      ST_CPU: begin
        m_cyc_o = c_cyc_i;
        m_stb_o = c_stb_i;
        m_we_o  = c_we_i;
        m_sel_o = c_sel_i;
        m_adr_o = c_adr_i;
        m_dat_o = c_dat_i;
        c_ack   = m_ack_i & c_cyc_i & c_stb_i;
      end
      default: ;
    endcase
  end

  assign v_ack_o = v_ack;
  assign c_ack_o = c_ack;
  // Read data is broadcast; each master qualifies it with its own ack.
  assign v_dat_o = m_dat_i;
  assign c_dat_o = m_dat_i;

  // Next grant: V wins ties; a waiting CPU steals one slot after a long V run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (v_cyc_i)      state_d = ST_VID;
        else if (c_cyc_i) state_d = ST_CPU;
      end
      ST_VID: begin
        if (!v_cyc_i)
          state_d = c_cyc_i ? ST_CPU : ST_IDLE;
        else if (STEAL_ENA && m_ack_i && c_cyc_i && run_q == RUN_LAST)
          state_d = ST_CPU;
      end
      ST_CPU: begin
        if (!c_cyc_i)
          state_d = v_cyc_i ? ST_VID : ST_IDLE;
        else if (c_stb_i && m_ack_i && v_cyc_i)
          state_d = ST_VID;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Run counter: counts V acks only while the CPU is waiting, saturating.
  always_comb begin
    run_d = run_q;
    if (!c_cyc_i)
      run_d = 8'd0;
    else if (state_q == ST_VID && state_d != ST_VID)
      run_d = 8'd0;
    else if (v_ack && run_q != 8'hFF)
      run_d = run_q + 8'd1;
  end

endmodule
